vga_timing_gen: RTL and testbench

Generates VGA raster timing: horizontal and vertical counters, hsync/vsync, video_on, and the current pixel coordinates. Sits directly upstream of the colorizer and feeds its video_on input. pixel_row/pixel_column drive the world-map and icon lookups that produce world_pixel and icon. Default timing is 640x480 @ 60 Hz from a 25 MHz pixel-rate tick.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_timing_gen_axis.sv | 33 +++
 rtl/vga_timing_gen.sv | 91 +++++++++
 tb/tb_vga_timing_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, sync encodings and timing bundle types
// shared by the VGA timing generator and its consumers.
package vga_timing_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int CNT_W_DEF = 10;
  localparam bit SYNC_ACTIVE_LOW = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;
  } vga_flags_t;
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic [CNT_W_DEF-1:0] row;
    logic [CNT_W_DEF-1:0] column;
  } vga_timing_t;
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction
endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter: wrapping position counter for one raster axis with
// active-region and sync-window decode of the current count.
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP = 16,
  parameter int SYNC = 96,
  parameter int BP = 48,
  parameter int CNT_W = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             carry_o,
  output logic             first_o,
  output logic             active_o,
  output logic             sync_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign carry_o = en_i && cnt_q == LAST;
  assign first_o = cnt_q == '0;
  assign active_o = cnt_q < ACT_END;
  assign sync_o = cnt_q >= SYNC_LO && cnt_q < SYNC_HI;
  assign cnt_o = cnt_q;
  always_comb cnt_d = !en_i ? cnt_q : carry_o ? '0 : cnt_q + CNT_W'(1);
  always_ff @(posedge clock)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (counters, syncs, video_on, coordinates) on a prescaled pixel tick.
// Define VGA_TIMING_SYNC_ALIGN_EN to delay hsync/vsync one clock to line up with registered colour.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int CLK_DIV = 1,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_column,
  output logic [CNT_W-1:0] pixel_row,
  output logic             line_start,
  output logic             frame_start
);
  localparam logic IDLE = sync_level(1'b0, SYNC_POL);
  logic [2:0] presc_q, presc_d;
  logic tick, h_carry, h_first, v_first, h_act, v_act, h_sync, v_sync, unused_v_carry;
  logic [CNT_W-1:0] h_cnt, v_cnt, col_q, row_q;
  logic pix_tick_q;
  vga_flags_t flags_d, flags_q;
  assign tick = presc_q == 3'(CLK_DIV - 1);
  always_comb presc_d = tick ? '0 : presc_q + 3'd1;
  always_ff @(posedge clock)
    if (!reset_n) presc_q <= '0;
    else presc_q <= presc_d;
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
  ) u_h (
    .clock(clock), .reset_n(reset_n), .en_i(tick), .cnt_o(h_cnt), .carry_o(h_carry),
    .first_o(h_first), .active_o(h_act), .sync_o(h_sync)
  );
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
  ) u_v (
    .clock(clock), .reset_n(reset_n), .en_i(h_carry), .cnt_o(v_cnt), .carry_o(unused_v_carry),
    .first_o(v_first), .active_o(v_act), .sync_o(v_sync)
  );
  always_comb begin
    flags_d.hsync = sync_level(h_sync, SYNC_POL);
    flags_d.vsync = sync_level(v_sync, SYNC_POL);
    flags_d.video_on = h_act && v_act;
    flags_d.line_start = h_first;
    flags_d.frame_start = h_first && v_first;
  end
  // Outputs present the decode of the position the counters held at the tick.
  always_ff @(posedge clock)
    if (!reset_n) begin
      flags_q <= {IDLE, IDLE, 3'b000};
      col_q <= '0;
      row_q <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      pix_tick_q <= tick;
      if (tick) begin
        flags_q <= flags_d;
        col_q <= h_cnt;
        row_q <= v_cnt;
      end
    end
  assign pix_tick = pix_tick_q;
  assign video_on = flags_q.video_on;
  assign line_start = flags_q.line_start;
  assign frame_start = flags_q.frame_start;
  assign pixel_column = col_q;
  assign pixel_row = row_q;
`ifdef VGA_TIMING_SYNC_ALIGN_EN
  logic hsync_q, vsync_q;
  always_ff @(posedge clock)
    if (!reset_n) {hsync_q, vsync_q} <= {IDLE, IDLE};
    else {hsync_q, vsync_q} <= {flags_q.hsync, flags_q.vsync};
  assign hsync = hsync_q;
  assign vsync = vsync_q;
`else
  assign hsync = flags_q.hsync;
  assign vsync = flags_q.vsync;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the default 640x480 timing and of a
// small active-high, divide-by-4 configuration used for frame-level behaviour.
module tb_vga_timing_gen;
`ifdef VGA_TIMING_SYNC_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic a_pix, a_hs, a_vs, a_vo, a_ls, a_fs;
  logic [9:0] a_col, a_row;
  logic b_pix, b_hs, b_vs, b_vo, b_ls, b_fs;
  logic [4:0] b_col, b_row;
  logic [5:0] a_flags, b_flags;
  assign a_flags = {a_pix, a_hs, a_vs, a_vo, a_ls, a_fs};
  assign b_flags = {b_pix, b_hs, b_vs, b_vo, b_ls, b_fs};
  always #5 clk = ~clk;
  vga_timing_gen dut_a (
    .clock(clk), .reset_n(rst_a), .pix_tick(a_pix), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vo), .pixel_column(a_col), .pixel_row(a_row),
    .line_start(a_ls), .frame_start(a_fs)
  );
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .CLK_DIV(4), .CNT_W(5)
  ) dut_b (
    .clock(clk), .reset_n(rst_b), .pix_tick(b_pix), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vo), .pixel_column(b_col), .pixel_row(b_row),
    .line_start(b_ls), .frame_start(b_fs)
  );
  task automatic test_reset;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (a_flags !== 6'b011000 || a_col !== 10'd0 || a_row !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_a got flags=%b col=%0d row=%0d exp flags=011000 col=0 row=0", a_flags, a_col, a_row);
    end
    n_cmp++;
    if (b_flags !== 6'b000000 || b_col !== 5'd0 || b_row !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_b got flags=%b col=%0d row=%0d exp flags=000000 col=0 row=0", b_flags, b_col, b_row);
    end
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (a_flags !== 6'b111111 || a_col !== 10'd0 || a_row !== 10'd0) begin
      n_bad++;
      $display("FAIL first_tick_a got flags=%b col=%0d row=%0d exp flags=111111 col=0 row=0", a_flags, a_col, a_row);
    end
  endtask
  task automatic test_line;
    int ec, er, vo_n, hs_n, ls_n, hs_first;
    logic phs, hs_r, ehs, evo, els;
    vo_n = 0; hs_n = 0; ls_n = 0; hs_first = -1;
    phs = 1'b1;
    for (int i = 1; i < 1600; i++) begin
      @(posedge clk);
      #1;
      ec = i % 800;
      er = i / 800;
      evo = ec < 640;
      hs_r = !(ec >= 656 && ec < 752);
      ehs = ALIGN ? phs : hs_r;
      phs = hs_r;
      els = ec == 0;
      n_cmp++;
      if (a_flags !== {1'b1, ehs, 1'b1, evo, els, 1'b0} || a_col !== 10'(ec) || a_row !== 10'(er)) begin
        n_bad++;
        $display("FAIL line_a i=%0d got flags=%b col=%0d row=%0d exp flags=%b col=%0d row=%0d",
                 i, a_flags, a_col, a_row, {1'b1, ehs, 1'b1, evo, els, 1'b0}, ec, er);
      end
      if (i >= 800) begin
        vo_n += int'(a_vo);
        hs_n += int'(!a_hs);
        ls_n += int'(a_ls);
        if (!a_hs && hs_first < 0) hs_first = int'(a_col);
      end
    end
    n_cmp++;
    if (vo_n != 640) begin
      n_bad++;
      $display("FAIL video_on_width got %0d exp 640", vo_n);
    end
    n_cmp++;
    if (hs_n != 96) begin
      n_bad++;
      $display("FAIL hsync_width got %0d exp 96", hs_n);
    end
    n_cmp++;
    if (ls_n != 1) begin
      n_bad++;
      $display("FAIL line_start_count got %0d exp 1", ls_n);
    end
    n_cmp++;
    if (hs_first != (ALIGN ? 657 : 656)) begin
      n_bad++;
      $display("FAIL hsync_first_col got %0d exp %0d", hs_first, ALIGN ? 657 : 656);
    end
  endtask
  task automatic test_frame_clkdiv;
    int p, ec, er, fs0, fs1, ls0, ls1, vs_n, pt_n;
    logic phs, pvs, pfs, pls, hs_r, vs_r, ehs, evs, epix, evo, els, efs;
    fs0 = -1; fs1 = -1; ls0 = -1; ls1 = -1; vs_n = 0; pt_n = 0;
    phs = 1'b0; pvs = 1'b0; pfs = 1'b0; pls = 1'b0;
    rst_b = 1'b1;
    for (int c = 1; c <= 1544; c++) begin
      @(posedge clk);
      #1;
      if (c < 4) begin
        ec = 0; er = 0; epix = 0; evo = 0; els = 0; efs = 0; hs_r = 0; vs_r = 0;
      end else begin
        p = c / 4 - 1;
        ec = p % 16;
        er = (p / 16) % 12;
        epix = c % 4 == 0;
        evo = ec < 8 && er < 6;
        hs_r = ec >= 10 && ec < 13;
        vs_r = er >= 8 && er < 10;
        els = ec == 0;
        efs = ec == 0 && er == 0;
      end
      ehs = ALIGN ? phs : hs_r;
      evs = ALIGN ? pvs : vs_r;
      phs = hs_r;
      pvs = vs_r;
      n_cmp++;
      if (b_flags !== {epix, ehs, evs, evo, els, efs} || b_col !== 5'(ec) || b_row !== 5'(er)) begin
        n_bad++;
        $display("FAIL frame_b c=%0d got flags=%b col=%0d row=%0d exp flags=%b col=%0d row=%0d",
                 c, b_flags, b_col, b_row, {epix, ehs, evs, evo, els, efs}, ec, er);
      end
      if (b_fs && !pfs) begin
        if (fs0 < 0) fs0 = c;
        else if (fs1 < 0) fs1 = c;
      end
      if (b_ls && !pls) begin
        if (ls0 < 0) ls0 = c;
        else if (ls1 < 0) ls1 = c;
      end
      pfs = b_fs;
      pls = b_ls;
      if (c >= 4 && c < 772) begin
        vs_n += int'(b_vs);
        pt_n += int'(b_pix);
      end
    end
    n_cmp++;
    if (fs0 != 4 || fs1 - fs0 != 768) begin
      n_bad++;
      $display("FAIL frame_period got first=%0d period=%0d exp first=4 period=768", fs0, fs1 - fs0);
    end
    n_cmp++;
    if (ls1 - ls0 != 64) begin
      n_bad++;
      $display("FAIL line_period got %0d exp 64", ls1 - ls0);
    end
    n_cmp++;
    if (vs_n != 128) begin
      n_bad++;
      $display("FAIL vsync_width got %0d exp 128", vs_n);
    end
    n_cmp++;
    if (pt_n != 192) begin
      n_bad++;
      $display("FAIL pix_tick_count got %0d exp 192", pt_n);
    end
  endtask
  task automatic test_mid_reset;
    int k;
    k = 0;
    while (k < 1000 && !(b_row == 5'd4 && b_col == 5'd5)) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (k >= 1000) begin
      n_bad++;
      $display("FAIL mid_reset_wait got timeout exp row=4 col=5");
    end
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    n_cmp++;
    if (b_flags !== 6'b000000 || b_col !== 5'd0 || b_row !== 5'd0) begin
      n_bad++;
      $display("FAIL mid_reset_b got flags=%b col=%0d row=%0d exp flags=000000 col=0 row=0", b_flags, b_col, b_row);
    end
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (b_flags !== (c == 4 ? 6'b100111 : 6'b000000) || b_col !== 5'd0 || b_row !== 5'd0) begin
        n_bad++;
        $display("FAIL restart_b c=%0d got flags=%b col=%0d row=%0d exp flags=%b col=0 row=0",
                 c, b_flags, b_col, b_row, c == 4 ? 6'b100111 : 6'b000000);
      end
    end
  endtask
  initial begin
    test_reset();
    test_line();
    test_frame_clkdiv();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
